// File: rtl/memory_access_stage_if.sv
// Data-memory request/acknowledge bus between the memory stage and the data memory.
interface memory_access_stage_if #(
    parameter int unsigned WORD = 32
);
    logic            dmem_req_o;
    logic            dmem_we_o;
    logic [WORD-1:0] dmem_addr_o;
    logic [3:0]      dmem_be_o;
    logic [WORD-1:0] dmem_wdata_o;
    logic [WORD-1:0] dmem_rdata_i;
    logic            dmem_ack_i;

    modport master (
        output dmem_req_o,
        output dmem_we_o,
        output dmem_addr_o,
        output dmem_be_o,
        output dmem_wdata_o,
        input  dmem_rdata_i,
        input  dmem_ack_i
    );

    modport slave (
        input  dmem_req_o,
        input  dmem_we_o,
        input  dmem_addr_o,
        input  dmem_be_o,
        input  dmem_wdata_o,
        output dmem_rdata_i,
        output dmem_ack_i
    );
endinterface

// File: rtl/memory_access_stage.sv
// Pipeline memory stage: issues loads/stores over a req/ack bus, stalls upstream while
// an access is outstanding, and presents aligned/extended writeback data to MEM/WB.
module memory_access_stage #(
    parameter int unsigned WORD       = 32,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic                  is_valid_i,
    input  logic                  mem_read_en_i,
    input  logic                  mem_write_en_i,
    input  logic [1:0]            mem_size_i,
    input  logic                  mem_sign_ext_i,
    input  logic                  reg_file_write_en_i,
    input  logic [ADDR_WIDTH-1:0] reg_dest_addr_i,
    input  logic [WORD-1:0]       alu_result_i,
    input  logic [WORD-1:0]       reg_2_data_i,
    output logic                  stall_o,
    memory_access_stage_if.master dmem,
    output logic                  wb_valid_o,
    output logic                  wb_reg_write_en_o,
    output logic [ADDR_WIDTH-1:0] wb_reg_dest_addr_o,
    output logic [WORD-1:0]       wb_data_o,
    output logic                  misalign_fault_o
);

    localparam int unsigned BE_W    = 4;
    localparam int unsigned SHIFT_W = 5;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;

    typedef struct packed {
        logic [WORD-1:0]       addr;
        logic [1:0]            size;
        logic                  sign_ext;
        logic                  we;
        logic [ADDR_WIDTH-1:0] dest;
        logic                  reg_we;
        logic [BE_W-1:0]       be;
        logic [WORD-1:0]       wdata;
    } mem_req_t;

    logic [0:0]            state_q, state_d;
    mem_req_t              req_q, req_d;
    logic                  wb_valid_q, wb_valid_d;
    logic                  wb_we_q, wb_we_d;
    logic [ADDR_WIDTH-1:0] wb_dest_q, wb_dest_d;
    logic [WORD-1:0]       wb_data_q, wb_data_d;
    logic                  fault_q, fault_d;

    logic                  mem_op_c;
    logic                  aligned_c;
    logic                  stall_c;
    logic                  busy_c;
    logic [BE_W-1:0]       st_be_c;
    logic [WORD-1:0]       st_wdata_c;
    logic [WORD-1:0]       ld_shift_c;
    logic [WORD-1:0]       ld_data_c;

    assign mem_op_c = is_valid_i & (mem_read_en_i | mem_write_en_i);

    // Alignment check; reserved size behaves as word
    always_comb begin
        aligned_c = 1'b1;
        case (mem_size_i)
            SIZE_BYTE: aligned_c = 1'b1;
            SIZE_HALF: aligned_c = ~alu_result_i[0];
            default:   aligned_c = (alu_result_i[1:0] == 2'b00);
        endcase
    end

    // Store byte-lane enables and replicated write data, computed at capture time
    always_comb begin
        st_be_c    = 4'b1111;
        st_wdata_c = reg_2_data_i;
        case (mem_size_i)
            SIZE_BYTE: begin
                st_be_c    = BE_W'(4'b0001 << alu_result_i[1:0]);
                st_wdata_c = {4{reg_2_data_i[7:0]}};
            end
            SIZE_HALF: begin
                st_be_c    = BE_W'(4'b0011 << alu_result_i[1:0]);
                st_wdata_c = {2{reg_2_data_i[15:0]}};
            end
            default: begin
                st_be_c    = 4'b1111;
                st_wdata_c = reg_2_data_i;
            end
        endcase
    end

    // Load lane extraction and extension from the captured offset/size/sign
    always_comb begin
        ld_shift_c = dmem.dmem_rdata_i >> SHIFT_W'({req_q.addr[1:0], 3'b000});
        ld_data_c  = dmem.dmem_rdata_i;
        case (req_q.size)
            SIZE_BYTE: ld_data_c = {{(WORD-8){req_q.sign_ext & ld_shift_c[7]}}, ld_shift_c[7:0]};
            SIZE_HALF: ld_data_c = {{(WORD-16){req_q.sign_ext & ld_shift_c[15]}}, ld_shift_c[15:0]};
            default:   ld_data_c = dmem.dmem_rdata_i;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= IDLE;
            req_q      <= '0;
            wb_valid_q <= 1'b0;
            wb_we_q    <= 1'b0;
            wb_dest_q  <= '0;
            wb_data_q  <= '0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            wb_valid_q <= wb_valid_d;
            wb_we_q    <= wb_we_d;
            wb_dest_q  <= wb_dest_d;
            wb_data_q  <= wb_data_d;
            fault_q    <= fault_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        wb_valid_d = 1'b0;
        wb_we_d    = 1'b0;
        wb_dest_d  = wb_dest_q;
        wb_data_d  = wb_data_q;
        fault_d    = 1'b0;
        stall_c    = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_op_c) begin
                    if (aligned_c) begin
                        stall_c        = 1'b1;
                        state_d        = BUSY;
                        req_d.addr     = alu_result_i;
                        req_d.size     = mem_size_i;
                        req_d.sign_ext = mem_sign_ext_i;
                        req_d.we       = mem_write_en_i;
                        req_d.dest     = reg_dest_addr_i;
                        req_d.reg_we   = reg_file_write_en_i;
                        req_d.be       = st_be_c;
                        req_d.wdata    = st_wdata_c;
                    end else begin
                        fault_d = 1'b1;
                    end
                end else begin
                    wb_valid_d = is_valid_i;
                    wb_we_d    = reg_file_write_en_i & is_valid_i;
                    wb_dest_d  = reg_dest_addr_i;
                    wb_data_d  = alu_result_i;
                end
            end
            BUSY: begin
                stall_c = ~dmem.dmem_ack_i;
                if (dmem.dmem_ack_i) begin
                    state_d    = IDLE;
                    wb_valid_d = 1'b1;
                    wb_we_d    = req_q.reg_we & ~req_q.we;
                    wb_dest_d  = req_q.dest;
                    wb_data_d  = req_q.we ? '0 : ld_data_c;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Bus outputs come straight from the captured request, so they hold until ack
    assign busy_c             = (state_q == BUSY);
    assign dmem.dmem_req_o    = busy_c;
    assign dmem.dmem_we_o     = busy_c & req_q.we;
    assign dmem.dmem_addr_o   = busy_c ? {req_q.addr[WORD-1:2], 2'b00} : '0;
    assign dmem.dmem_be_o     = busy_c ? req_q.be : '0;
    assign dmem.dmem_wdata_o  = busy_c ? req_q.wdata : '0;

    // Held-upstream inputs must not raise stall while reset is asserted
    assign stall_o            = reset_n_i & stall_c;
    assign wb_valid_o         = wb_valid_q;
    assign wb_reg_write_en_o  = wb_we_q;
    assign wb_reg_dest_addr_o = wb_dest_q;
    assign wb_data_o          = wb_data_q;
    assign misalign_fault_o   = fault_q;

endmodule

// File: doc/memory_access_stage.md
Name: memory_access_stage

Overview:
- Memory stage between the execute/memory pipeline register and the memory/writeback register.
- Consumes the EX/MEM register outputs and issues loads and stores to the data memory over a req/ack handshake.
- Stalls the upstream pipeline while a memory access is outstanding.
- Presents aligned, extended writeback data plus control to the MEM/WB register.

Parameters:
WORD, 32, datapath width (must be 32; byte lanes assume 4)
ADDR_WIDTH, 4, register-file destination address width

Ports:
clk_i  in  1  clock
reset_n_i  in  1  reset, asynchronous, active-low
is_valid_i  in  1  upstream instruction valid
mem_read_en_i  in  1  instruction is a load
mem_write_en_i  in  1  instruction is a store
mem_size_i  in  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as word)
mem_sign_ext_i  in  1  load result sign-extended (1) or zero-extended (0)
reg_file_write_en_i  in  1  instruction writes a register
reg_dest_addr_i  in  ADDR_WIDTH  destination register
alu_result_i  in  WORD  effective address, or result for non-memory ops
reg_2_data_i  in  WORD  store data
stall_o  out  1  upstream must hold its outputs
dmem_req_o  out  1  memory request
dmem_we_o  out  1  request is a write
dmem_addr_o  out  WORD  word-aligned address ({addr[31:2],2'b00})
dmem_be_o  out  4  byte enables
dmem_wdata_o  out  WORD  lane-replicated store data
dmem_rdata_i  in  WORD  read data, valid with ack
dmem_ack_i  in  1  request complete
wb_valid_o  out  1  writeback instruction valid
wb_reg_write_en_o  out  1  register write enable
wb_reg_dest_addr_o  out  ADDR_WIDTH  destination register
wb_data_o  out  WORD  writeback data
misalign_fault_o  out  1  one-cycle pulse on a misaligned access

Behaviour:
- Clock and reset: one clock, clk_i. Reset is reset_n_i, asynchronous, active-low.
- On reset: state IDLE; all outputs 0, including the dmem_* outputs and the internal captured request.
- A reset mid-access abandons it. Any late ack is ignored, because ack is only sampled in BUSY.
- mem_op = is_valid_i & (mem_read_en_i | mem_write_en_i).
- Alignment:
  - halfword requires addr[0]=0;
  - word requires addr[1:0]=00;
  - byte is always aligned.
- FSM states: IDLE, BUSY.
- IDLE, no mem_op:
  - pass-through with 1-cycle latency;
  - at each edge, wb_valid_o<=is_valid_i, wb_reg_write_en_o<=reg_file_write_en_i&is_valid_i, wb_data_o<=alu_result_i, wb_reg_dest_addr_o<=reg_dest_addr_i;
  - stall_o=0.
- IDLE, aligned mem_op:
  - stall_o=1 combinationally;
  - at the edge, capture address, size, sign, we, dest, write-enable and store data; go to BUSY;
  - wb_valid_o<=0 (bubble).
- IDLE, misaligned mem_op:
  - no request;
  - misalign_fault_o<=1 for one cycle; wb_valid_o<=0 (squashed); stall_o=0.
- BUSY:
  - dmem_req_o=1 and dmem_we_o/addr/be/wdata are driven from the captured registers, stable until ack;
  - stall_o=!dmem_ack_i;
  - wb_valid_o=0 while waiting.
- BUSY with dmem_ack_i=1:
  - at that edge, go to IDLE;
  - wb_valid_o<=1, wb_reg_write_en_o<=captured write-enable & is_load;
  - wb_data_o<=extracted load data (don't-care, driven 0, for a store);
  - upstream advances on the same edge because stall_o was 0 in the ack cycle.
- Back-to-back memory ops: the next mem_op is presented in the ack cycle but only sampled in IDLE, so there is exactly one IDLE cycle between accesses. Minimum access latency is 2 cycles (accept edge, ack edge).
- Store byte lanes (off=addr[1:0]):
  - byte: be=4'b0001<<off, wdata={4{data[7:0]}};
  - half: be=4'b0011<<off, wdata={2{data[15:0]}};
  - word: be=4'b1111, wdata=data.
- Load extraction:
  - byte: rdata>>(8*off), low 8 bits;
  - half: rdata>>(8*off), low 16 bits;
  - then sign- or zero-extend per mem_sign_ext;
  - word: unchanged.
- dmem_ack_i while IDLE is ignored.

Test Plan:
- Reset: reset_n_i low mid-BUSY, asynchronously (no clock edge) -> dmem_req_o=0 and stall_o=0 immediately; after release, a stray ack causes no wb_valid_o.
- ALU pass-through: alu_result_i=0x1234_5678, dest=3, wr_en=1, valid=1 -> next cycle wb_valid_o=1, wb_data_o=0x1234_5678, wb_reg_dest_addr_o=3, wb_reg_write_en_o=1.
- Signed byte load: addr=0x0000_0102, rdata=0x80FF_7F01, ack after 3 wait cycles:
  - stall_o=1 for 4 cycles;
  - wb_data_o=0xFFFF_FFFF (byte 0xFF sign-extended);
  - with zero-extend -> 0x0000_00FF.
- Halfword store: addr=0x0000_0012, data=0xAAAA_BEEF -> dmem_addr_o=0x0000_0010, dmem_be_o=4'b1100, dmem_wdata_o=0xBEEF_BEEF, dmem_we_o=1; wb_reg_write_en_o=0 after ack.
- Misaligned word load: addr=0x0000_0006 -> dmem_req_o stays 0, misalign_fault_o pulses for 1 cycle, wb_valid_o=0, stall_o=0.
- Back-to-back: word load then word store, each acked on its first BUSY cycle -> exactly one IDLE cycle between the two dmem_req_o assertions; both ops visible at wb, no op lost or duplicated.
